// File: rtl/vga_scanout_pkg.sv
// Shared VGA timing defaults (640x480@60) and the small types used by the scanout path.
package vga_scanout_pkg;

    localparam int VGA_HOR_ACTIVE      = 640;
    localparam int VGA_HOR_FRONT_PORCH = 16;
    localparam int VGA_HOR_SYNC_PULSE  = 96;
    localparam int VGA_HOR_BACK_PORCH  = 48;

    localparam int VGA_VER_ACTIVE      = 480;
    localparam int VGA_VER_FRONT_PORCH = 10;
    localparam int VGA_VER_SYNC_PULSE  = 2;
    localparam int VGA_VER_BACK_PORCH  = 33;

    // Full period of one axis: visible region plus the three blanking intervals.
    function automatic int axis_total(input int active, input int front, input int pulse,
                                      input int back);
        return active + front + pulse + back;
    endfunction

    localparam int VGA_HOR_TOTAL    = axis_total(VGA_HOR_ACTIVE, VGA_HOR_FRONT_PORCH,
                                                 VGA_HOR_SYNC_PULSE, VGA_HOR_BACK_PORCH);
    localparam int VGA_VER_TOTAL    = axis_total(VGA_VER_ACTIVE, VGA_VER_FRONT_PORCH,
                                                 VGA_VER_SYNC_PULSE, VGA_VER_BACK_PORCH);
    localparam int VGA_PIXELS_COUNT = VGA_HOR_ACTIVE * VGA_VER_ACTIVE;

    // Timing flags that travel together down the alignment pipeline; syncs are active-low.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};

endpackage

// File: rtl/vga_scanout_sync_gen.sv
// Horizontal/vertical raster counters and the undelayed (stage-0) sync and active flags.
module vga_sync_gen
    import vga_scanout_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = VGA_HOR_ACTIVE,
    parameter int VER_ACTIVE_PIXELS = VGA_VER_ACTIVE,
    parameter int HOR_FRONT_PORCH   = VGA_HOR_FRONT_PORCH,
    parameter int HOR_SYNC_PULSE    = VGA_HOR_SYNC_PULSE,
    parameter int HOR_BACK_PORCH    = VGA_HOR_BACK_PORCH,
    parameter int VER_FRONT_PORCH   = VGA_VER_FRONT_PORCH,
    parameter int VER_SYNC_PULSE    = VGA_VER_SYNC_PULSE,
    parameter int VER_BACK_PORCH    = VGA_VER_BACK_PORCH,
    localparam int HOR_TOTAL = axis_total(HOR_ACTIVE_PIXELS, HOR_FRONT_PORCH,
                                          HOR_SYNC_PULSE, HOR_BACK_PORCH),
    localparam int VER_TOTAL = axis_total(VER_ACTIVE_PIXELS, VER_FRONT_PORCH,
                                          VER_SYNC_PULSE, VER_BACK_PORCH),
    localparam int H_W = $clog2(HOR_TOTAL),
    localparam int V_W = $clog2(VER_TOTAL)
) (
    input  logic           clk,
    input  logic           rst,
    output logic [H_W-1:0] h,
    output logic [V_W-1:0] v,
    output sync_t          stage0
);

    localparam logic [H_W-1:0] H_LAST       = H_W'(HOR_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACTIVE     = H_W'(HOR_ACTIVE_PIXELS);
    localparam logic [H_W-1:0] H_SYNC_START = H_W'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH);
    localparam logic [H_W-1:0] H_SYNC_END   = H_W'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH
                                                   + HOR_SYNC_PULSE);
    localparam logic [V_W-1:0] V_LAST       = V_W'(VER_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACTIVE     = V_W'(VER_ACTIVE_PIXELS);
    localparam logic [V_W-1:0] V_SYNC_START = V_W'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH);
    localparam logic [V_W-1:0] V_SYNC_END   = V_W'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH
                                                   + VER_SYNC_PULSE);

    // Advance the raster: h every clock, v once per line, both wrapping at their totals.
    always_ff @(posedge clk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    // Decode the current raster position into visible-area and sync-pulse flags.
    always_comb begin
        stage0        = SYNC_IDLE;
        stage0.active = (h < H_ACTIVE) && (v < V_ACTIVE);
        stage0.hsync  = !((h >= H_SYNC_START) && (h < H_SYNC_END));
        stage0.vsync  = !((v >= V_SYNC_START) && (v < V_SYNC_END));
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: walks the frame buffer linearly, requests a buffer swap once per frame,
// and aligns pixel data with the sync signals through a two-clock pipeline.
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = VGA_HOR_ACTIVE,
    parameter int VER_ACTIVE_PIXELS = VGA_VER_ACTIVE,
    parameter int HOR_FRONT_PORCH   = VGA_HOR_FRONT_PORCH,
    parameter int HOR_SYNC_PULSE    = VGA_HOR_SYNC_PULSE,
    parameter int HOR_BACK_PORCH    = VGA_HOR_BACK_PORCH,
    parameter int VER_FRONT_PORCH   = VGA_VER_FRONT_PORCH,
    parameter int VER_SYNC_PULSE    = VGA_VER_SYNC_PULSE,
    parameter int VER_BACK_PORCH    = VGA_VER_BACK_PORCH,
    localparam int HOR_TOTAL    = axis_total(HOR_ACTIVE_PIXELS, HOR_FRONT_PORCH,
                                             HOR_SYNC_PULSE, HOR_BACK_PORCH),
    localparam int VER_TOTAL    = axis_total(VER_ACTIVE_PIXELS, VER_FRONT_PORCH,
                                             VER_SYNC_PULSE, VER_BACK_PORCH),
    localparam int PIXELS_COUNT = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS,
    localparam int ADDR_WIDTH   = $clog2(PIXELS_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  read_data,
    output logic                  swap,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  display_enable,
    output logic                  pixel
);

    localparam int H_W = $clog2(HOR_TOTAL);
    localparam int V_W = $clog2(VER_TOTAL);

    localparam logic [H_W-1:0]        H_LAST     = H_W'(HOR_TOTAL - 1);
    localparam logic [V_W-1:0]        V_LAST     = V_W'(VER_TOTAL - 1);
    localparam logic [V_W-1:0]        V_SWAP_ARM = V_W'(VER_ACTIVE_PIXELS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(PIXELS_COUNT - 1);

    logic [H_W-1:0] h;
    logic [V_W-1:0] v;
    sync_t          stage0;
    sync_t          stage1;
    logic           frame_end;

    vga_sync_gen #(
        .HOR_ACTIVE_PIXELS (HOR_ACTIVE_PIXELS),
        .VER_ACTIVE_PIXELS (VER_ACTIVE_PIXELS),
        .HOR_FRONT_PORCH   (HOR_FRONT_PORCH),
        .HOR_SYNC_PULSE    (HOR_SYNC_PULSE),
        .HOR_BACK_PORCH    (HOR_BACK_PORCH),
        .VER_FRONT_PORCH   (VER_FRONT_PORCH),
        .VER_SYNC_PULSE    (VER_SYNC_PULSE),
        .VER_BACK_PORCH    (VER_BACK_PORCH)
    ) u_sync_gen (
        .clk    (clk),
        .rst    (rst),
        .h      (h),
        .v      (v),
        .stage0 (stage0)
    );

    assign frame_end = (h == H_LAST) && (v == V_LAST);

    // Linear read address: steps once per visible pixel, parks on the last pixel
    // through vertical blanking, and rewinds so it reads 0 exactly at (0,0).
    always_ff @(posedge clk) begin
        if (rst || frame_end) begin
            read_addr <= '0;
        end else if (stage0.active && (read_addr != ADDR_LAST)) begin
            read_addr <= read_addr + 1'b1;
        end
    end

    // Swap request fires during raster (0, first blanking line), after the final visible read.
    always_ff @(posedge clk) begin
        if (rst) begin
            swap <= 1'b0;
        end else begin
            swap <= (h == H_LAST) && (v == V_SWAP_ARM);
        end
    end

    // Delay timing flags two clocks so they line up with the registered frame-buffer data.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage1         <= SYNC_IDLE;
            hsync          <= 1'b1;
            vsync          <= 1'b1;
            display_enable <= 1'b0;
            pixel          <= 1'b0;
        end else begin
            stage1         <= stage0;
            hsync          <= stage1.hsync;
            vsync          <= stage1.vsync;
            display_enable <= stage1.active;
            pixel          <= read_data & stage1.active;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout using a shrunken raster so several frames fit
// in a short run; outputs are compared each clock against a raster-position model.
module tb_vga_scanout;

    localparam int HA  = 16;
    localparam int VA  = 8;
    localparam int HFP = 2;
    localparam int HSP = 3;
    localparam int HBP = 4;
    localparam int VFP = 2;
    localparam int VSP = 2;
    localparam int VBP = 3;
    localparam int HT    = HA + HFP + HSP + HBP;
    localparam int VT    = VA + VFP + VSP + VBP;
    localparam int FRAME = HT * VT;
    localparam int PC    = HA * VA;
    localparam int AW    = $clog2(PC);

    logic          clk;
    logic          rst;
    logic [AW-1:0] read_addr;
    logic          read_data;
    logic          swap;
    logic          hsync;
    logic          vsync;
    logic          display_enable;
    logic          pixel;

    logic          mem [PC];
    int            t;
    int            last_addr;
    int            check_count;
    int            error_count;
    int            swaps_seen;
    int            swaps_expected;

    vga_scanout #(
        .HOR_ACTIVE_PIXELS (HA),
        .VER_ACTIVE_PIXELS (VA),
        .HOR_FRONT_PORCH   (HFP),
        .HOR_SYNC_PULSE    (HSP),
        .HOR_BACK_PORCH    (HBP),
        .VER_FRONT_PORCH   (VFP),
        .VER_SYNC_PULSE    (VSP),
        .VER_BACK_PORCH    (VBP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .read_addr      (read_addr),
        .read_data      (read_data),
        .swap           (swap),
        .hsync          (hsync),
        .vsync          (vsync),
        .display_enable (display_enable),
        .pixel          (pixel)
    );

    // Free-running pixel clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read address at a raster position: visible pixels already visited this frame,
    // saturated at the last pixel.
    function automatic int modelAddr(input int hh, input int vv);
        int cnt;
        if (vv < VA) cnt = vv * HA + ((hh < HA) ? hh : HA);
        else         cnt = PC;
        return (cnt > PC - 1) ? PC - 1 : cnt;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        assert (observed === expected) else begin
            error_count++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d (t=%0d)", tag, observed, expected, t);
        end
    endtask

    // Run n clocks out of reset, checking every output against the raster model.
    task automatic applyStimulus(input int n_cycles);
        for (int i = 0; i < n_cycles; i++) begin
            int   h0, v0, hd, vd;
            logic exp_swap, exp_de, exp_hs, exp_vs, exp_px;
            h0       = t % HT;
            v0       = (t / HT) % VT;
            exp_swap = (h0 == 0) && (v0 == VA);
            exp_de   = 1'b0;
            exp_hs   = 1'b1;
            exp_vs   = 1'b1;
            exp_px   = 1'b0;
            if (t >= 2) begin
                hd     = (t - 2) % HT;
                vd     = ((t - 2) / HT) % VT;
                exp_de = (hd < HA) && (vd < VA);
                exp_hs = !((hd >= HA + HFP) && (hd < HA + HFP + HSP));
                exp_vs = !((vd >= VA + VFP) && (vd < VA + VFP + VSP));
                exp_px = exp_de ? mem[vd * HA + hd] : 1'b0;
            end
            checkOutput("read_addr", int'(read_addr), modelAddr(h0, v0));
            checkOutput("swap", int'(swap), int'(exp_swap));
            checkOutput("hsync", int'(hsync), int'(exp_hs));
            checkOutput("vsync", int'(vsync), int'(exp_vs));
            checkOutput("display_enable", int'(display_enable), int'(exp_de));
            checkOutput("pixel", int'(pixel), int'(exp_px));
            swaps_seen     += int'(swap);
            swaps_expected += int'(exp_swap);
            // Frame-buffer model: registered read, data for last cycle's address.
            read_data = mem[last_addr];
            last_addr = int'(read_addr);
            t++;
            @(posedge clk);
            #1;
        end
    endtask

    // Hold reset for n clocks, checking reset values after each reset edge.
    task automatic applyReset(input int n_cycles);
        rst = 1'b1;
        for (int i = 0; i < n_cycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_read_addr", int'(read_addr), 0);
            checkOutput("rst_swap", int'(swap), 0);
            checkOutput("rst_hsync", int'(hsync), 1);
            checkOutput("rst_vsync", int'(vsync), 1);
            checkOutput("rst_display_enable", int'(display_enable), 0);
            checkOutput("rst_pixel", int'(pixel), 0);
            swaps_seen += int'(swap);
        end
        rst       = 1'b0;
        t         = 0;
        last_addr = 0;
    endtask

    // Advance to the given raster position within the current frame.
    task automatic runTo(input int hh, input int vv);
        applyStimulus(((vv * HT + hh) - (t % FRAME) + FRAME) % FRAME);
    endtask

    initial begin
        rst            = 1'b1;
        read_data      = 1'b0;
        t              = 0;
        last_addr      = 0;
        check_count    = 0;
        error_count    = 0;
        swaps_seen     = 0;
        swaps_expected = 0;
        for (int i = 0; i < PC; i++) mem[i] = 1'($urandom_range(0, 1));

        $display("[TB] vga_scanout bench, raster %0dx%0d, %0d clocks per frame", HT, VT, FRAME);
        @(posedge clk);
        #1;

        applyReset(3);
        applyStimulus(2 * FRAME + 50);

        // Reset in the middle of a line, well inside the visible frame.
        runTo(HT - 5, VA / 2 + 1);
        applyReset(3);
        applyStimulus(2 * FRAME);

        // Reset at a random position for a random number of clocks.
        applyStimulus($urandom_range(1, FRAME));
        applyReset($urandom_range(1, 4));
        applyStimulus(FRAME + 10);

        checkOutput("swap_total", swaps_seen, swaps_expected);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
